// File: rtl/regfile_wb_arb_if.sv
// Write-back bus between the result producers, the arbiter and the register file.
// The slave modport is the arbiter's view; master is the producers/register-file side.
interface regfile_wb_arb_if;
  logic        A_Valid;
  logic [4:0]  A_Addr;
  logic [63:0] A_Data;
  logic        A_Ready;
  logic        B_Valid;
  logic [4:0]  B_Addr;
  logic [63:0] B_Data;
  logic        B_Ready;
  logic        W_En;
  logic [4:0]  W_Addr;
  logic [63:0] WR;
  logic [31:0] Pend_Mask;

  modport master (
    output A_Valid, A_Addr, A_Data,
    output B_Valid, B_Addr, B_Data,
    input  A_Ready, B_Ready,
    input  W_En, W_Addr, WR, Pend_Mask
  );

  modport slave (
    input  A_Valid, A_Addr, A_Data,
    input  B_Valid, B_Addr, B_Data,
    output A_Ready, B_Ready,
    output W_En, W_Addr, WR, Pend_Mask
  );
endinterface

// File: rtl/regfile_wb_arb.sv
// Write-back arbiter for the 32x64 register file: the ALU (port A) has priority, the
// multi-cycle port B is queued in a small FIFO and guaranteed service by a starvation limit.
module regfile_wb_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic            clk,
  input  logic            reset,
  regfile_wb_arb_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] SLIM_C  = SW'(STARVE_LIM);

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_entry_t;

  wb_entry_t       fifo_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            w_en_q, w_en_d;
  logic [4:0]      w_addr_q, w_addr_d;
  logic [63:0]     wr_q, wr_d;

  logic            empty, full, starve;
  logic            a_ready, b_ready;
  logic            a_take, pop, push;
  logic [31:0]     pend_mask;

  // Handshake terms depend only on registered state and reset, never on the inputs.
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign starve  = !empty && (starve_cnt_q >= SLIM_C);
  assign a_ready = !reset && !starve;
  assign b_ready = !reset && !full;

  assign a_take  = bus.A_Valid && a_ready;
  assign pop     = !a_take && !empty;
  assign push    = bus.B_Valid && b_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_en_d       = 1'b0;
    w_addr_d     = w_addr_q;
    wr_d         = wr_q;
    starve_cnt_d = starve_cnt_q;
    rd_ptr_d     = rd_ptr_q;

    if (a_take) begin
      w_en_d   = 1'b1;
      w_addr_d = bus.A_Addr;
      wr_d     = bus.A_Data;
      if (!empty && (starve_cnt_q < SLIM_C)) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end else if (pop) begin
      w_en_d       = 1'b1;
      w_addr_d     = fifo_q[rd_ptr_q].addr;
      wr_d         = fifo_q[rd_ptr_q].data;
      starve_cnt_d = '0;
      rd_ptr_d     = rd_ptr_q + AW'(1);
    end
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ({1'b0, AW'(k) - rd_ptr_q} < count_q) begin
        pend_mask[fifo_q[k].addr] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      wr_q         <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      wr_q         <= wr_d;
    end
  end

  // NOTE: the FIFO storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {bus.B_Addr, bus.B_Data};
    end
  end

  assign bus.A_Ready   = a_ready;
  assign bus.B_Ready   = b_ready;
  assign bus.W_En      = w_en_q;
  assign bus.W_Addr    = w_addr_q;
  assign bus.WR        = wr_q;
  assign bus.Pend_Mask = pend_mask;

  count_in_range: assert property (@(posedge clk) disable iff (reset) count_q <= DEPTH_C);

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the arbitration rules.
module tb_regfile_wb_arb;

  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arb_if bus();

  regfile_wb_arb #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  // Reference model state
  wr_t         mq[$];
  int          ms     = 0;
  logic        e_wen  = 1'b0;
  logic [4:0]  e_waddr = '0;
  logic [63:0] e_wr   = '0;
  logic [63:0] m_rf [32];
  logic [63:0] d_rf [32];
  bit          m_take, m_bacc;
  wr_t         m_head;

  int errors = 0;
  int checks = 0;
  bit bad_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_starve();
    return (mq.size() > 0) && (ms >= LIM);
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].addr] = 1'b1;
    return m;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      ms      = 0;
      e_wen   = 1'b0;
      e_waddr = '0;
      e_wr    = '0;
    end else begin
      m_take = bus.A_Valid && !m_starve();
      m_bacc = bus.B_Valid && (mq.size() < DEPTH);
      if (m_take) begin
        e_wen   = 1'b1;
        e_waddr = bus.A_Addr;
        e_wr    = bus.A_Data;
        if (mq.size() > 0 && ms < LIM) ms++;
      end else if (mq.size() > 0) begin
        m_head  = mq.pop_front();
        e_wen   = 1'b1;
        e_waddr = m_head.addr;
        e_wr    = m_head.data;
        ms      = 0;
      end else begin
        e_wen = 1'b0;
      end
      if (e_wen) m_rf[e_waddr] = e_wr;
      if (m_bacc) mq.push_back('{bus.B_Addr, bus.B_Data});
    end
  end

  // Per-cycle comparison against the model; also shadows the register file from DUT writes.
  always @(negedge clk) begin
    check("W_En",      64'(bus.W_En),      64'(e_wen));
    check("W_Addr",    64'(bus.W_Addr),    64'(e_waddr));
    check("WR",        bus.WR,             e_wr);
    check("A_Ready",   64'(bus.A_Ready),   64'(!reset && !m_starve()));
    check("B_Ready",   64'(bus.B_Ready),   64'(!reset && (mq.size() < DEPTH)));
    check("Pend_Mask", 64'(bus.Pend_Mask), 64'(m_pend()));
    if (bus.W_En) begin
      d_rf[bus.W_Addr] = bus.WR;
      if (bus.WR[63:48] == 16'hBAD0) bad_seen = 1'b1;
    end
  end

  task automatic drive(input bit av, input logic [4:0] aa, input logic [63:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [63:0] bd);
    bus.A_Valid = av;
    bus.A_Addr  = aa;
    bus.A_Data  = ad;
    bus.B_Valid = bv;
    bus.B_Addr  = ba;
    bus.B_Data  = bd;
  endtask

  task automatic idle(input int n);
    drive(0, '0, '0, 0, '0, '0);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    drive(0, '0, '0, 0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_W_En",    64'(bus.W_En), 64'd0);
    check("rst_A_Ready", 64'(bus.A_Ready), 64'd0);
    check("rst_B_Ready", 64'(bus.B_Ready), 64'd0);
    check("rst_Pend",    64'(bus.Pend_Mask), 64'd0);
    #2 reset = 1'b0;
    @(negedge clk);

    // Port A latency
    drive(1, 5'd5, 64'hDEAD_BEEF_0000_0001, 0, '0, '0);
    @(negedge clk);
    check("a_lat_wen",  64'(bus.W_En), 64'd1);
    check("a_lat_addr", 64'(bus.W_Addr), 64'd5);
    check("a_lat_data", bus.WR, 64'hDEAD_BEEF_0000_0001);
    idle(1);
    check("a_lat_r5",   d_rf[5], 64'hDEAD_BEEF_0000_0001);
    check("a_lat_m_r5", m_rf[5], 64'hDEAD_BEEF_0000_0001);
    idle(2);

    // Fill and drain with A idle: each write two cycles after its push
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, '0, 1, 5'(i + 1), 64'h100 + 64'(i));
      @(negedge clk);
      check("fill_b_ready", 64'(bus.B_Ready), 64'd1);
      if (i > 0) check("fill_order", 64'(bus.W_Addr), 64'(i));
    end
    idle(1);
    check("fill_last", 64'(bus.W_Addr), 64'd4);
    idle(3);

    // Full FIFO under continuous A traffic
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd20, 64'h2000 + 64'(i), 1, 5'(7 + i), 64'h700 + 64'(i));
      @(negedge clk);
    end
    check("full_b_ready", 64'(bus.B_Ready), 64'd0);
    check("full_pend",    64'(bus.Pend_Mask), 64'h0000_0780);
    drive(1, 5'd20, 64'h2100, 1, 5'd11, 64'h7FF);
    n = 0;
    while (!bus.B_Ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("full_b5_wait", 64'(n), 64'd6);
    @(negedge clk);
    idle(10);

    // Starvation: one B entry against continuous A traffic
    drive(1, 5'd21, 64'h2121, 1, 5'd12, 64'hC0C0);
    @(negedge clk);
    drive(1, 5'd21, 64'h2121, 0, '0, '0);
    n = 0;
    while (bus.A_Ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("starve_a_writes", 64'(n), 64'd8);
    @(negedge clk);
    check("starve_b_addr",  64'(bus.W_Addr), 64'd12);
    check("starve_b_data",  bus.WR, 64'hC0C0);
    check("starve_a_ready", 64'(bus.A_Ready), 64'd1);
    @(negedge clk);
    check("starve_resume",  64'(bus.W_Addr), 64'd21);
    idle(3);

    // Same-address ordering: A write to R3 overtakes the queued B write
    drive(1, 5'd21, 64'h2121, 1, 5'd3, 64'h1);
    @(negedge clk);
    check("same_pend0", 64'(bus.Pend_Mask[3]), 64'd1);
    drive(1, 5'd3, 64'h2, 0, '0, '0);
    @(negedge clk);
    check("same_a_addr", 64'(bus.W_Addr), 64'd3);
    check("same_a_data", bus.WR, 64'h2);
    check("same_pend1",  64'(bus.Pend_Mask[3]), 64'd1);
    idle(1);
    check("same_b_addr", 64'(bus.W_Addr), 64'd3);
    check("same_b_data", bus.WR, 64'h1);
    check("same_pend2",  64'(bus.Pend_Mask[3]), 64'd0);
    idle(1);
    check("same_r3",   d_rf[3], 64'h1);
    check("same_m_r3", m_rf[3], 64'h1);
    idle(2);

    // Asynchronous reset mid-cycle with a full FIFO and a write in flight
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd22, 64'h2222, 1, 5'(13 + i), 64'hBAD0_0000_0000_0000 + 64'(i));
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_wen",  64'(bus.W_En), 64'd0);
    check("mid_rst_a",    64'(bus.A_Ready), 64'd0);
    check("mid_rst_b",    64'(bus.B_Ready), 64'd0);
    check("mid_rst_pend", 64'(bus.Pend_Mask), 64'd0);
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    #2 reset = 1'b0;
    idle(12);
    check("flush_no_write", 64'(bad_seen), 64'd0);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) < 65, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), {16'h5A5A, 16'($urandom), $urandom});
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
      @(negedge clk);
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
